// File: rtl/operand_issuer.sv
// rtl/operand_issuer.sv - issues buffered operand pairs to a fixed-latency unit
// and returns each captured result through a valid/ready response port.
module operand_issuer #(
   parameter int WIDTH      = 32,
   parameter int LATENCY    = 3,
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_fast,
   output logic [WIDTH-1:0] opa,
   output logic [WIDTH-1:0] opb,
   output logic             fast,
   input  logic [WIDTH-1:0] out,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic             resp_zero,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(LATENCY + 1);
   localparam int EW = 2 * WIDTH + 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state, state_nx;

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [PW:0]   wr_ptr, rd_ptr;
   logic [CW-1:0] cnt;
   logic          empty, full, push, pop, capture;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign req_ready = !full;
   assign push      = req_valid && !full;
   assign busy      = (state != IDLE) || !empty;
   assign resp_zero = (resp_data == '0);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      capture  = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               capture  = 1'b1;
               state_nx = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               pop      = !empty;
               state_nx = empty ? IDLE : WAIT;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[PW-1:0]] <= {req_fast, req_b, req_a};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         opa        <= '0;
         opb        <= '0;
         fast       <= 1'b0;
         cnt        <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         done_cnt   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         // Operands only move at an issue edge and are held until the next one.
         if (pop) begin
            {fast, opb, opa} <= mem[rd_ptr[PW-1:0]];
            rd_ptr           <= rd_ptr + 1'b1;
            cnt              <= CW'(LATENCY);
         end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (capture) begin
            resp_data  <= out;
            resp_valid <= 1'b1;
         end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            done_cnt   <= done_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_operand_issuer.sv
// tb/tb_operand_issuer.sv - scoreboard bench for operand_issuer with an adder
// unit model behind a LATENCY-deep register pipeline.
module tb_operand_issuer;
   localparam int WIDTH = 32;
   localparam int LAT   = 3;
   localparam int DEPTH = 2;
   localparam int CNT_W = 6;

   logic             clk = 1'b0;
   logic             rst, req_valid, req_ready, req_fast, fast;
   logic             resp_valid, resp_ready, resp_zero, busy;
   logic [WIDTH-1:0] req_a, req_b, opa, opb, out, resp_data;
   logic [CNT_W-1:0] done_cnt;
   logic [WIDTH-1:0] pipe [LAT];

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             f;
   } op_t;

   op_t              sb[$];
   logic [CNT_W-1:0] exp_done;
   int               vectors = 0;
   int               miscompares = 0;
   int               cyc = 0;

   operand_issuer #(.WIDTH(WIDTH), .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_fast(req_fast),
      .opa(opa), .opb(opb), .fast(fast), .out(out),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_zero(resp_zero),
      .busy(busy), .done_cnt(done_cnt)
   );

   always #5 clk = ~clk;

   // Unit model: no reset, result appears LAT edges after operands are presented.
   always_ff @(posedge clk) begin
      pipe[0] <= opa + opb;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign out = pipe[LAT-1];

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   // Response monitor: scoreboard compare, hold checks, operand stability over the wait window.
   initial begin
      logic             prev_rv, prev_hs, stable;
      logic [WIDTH-1:0] prev_d, prev_a, prev_b, sum;
      logic [WIDTH-1:0] ha [LAT+2];
      logic [WIDTH-1:0] hb [LAT+2];
      logic             hf [LAT+2];
      op_t              e;
      prev_rv  = 1'b0;
      prev_hs  = 1'b0;
      prev_d   = '0;
      prev_a   = '0;
      prev_b   = '0;
      exp_done = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_rv  = 1'b0;
            prev_hs  = 1'b0;
            exp_done = '0;
            sb.delete();
         end else begin
            for (int k = LAT + 1; k > 0; k--) begin
               ha[k] = ha[k-1];
               hb[k] = hb[k-1];
               hf[k] = hf[k-1];
            end
            ha[0] = opa;
            hb[0] = opb;
            hf[0] = fast;
            if (prev_rv && !prev_hs) begin
               vectors++;
               if ({resp_valid, resp_data, opa, opb} !== {1'b1, prev_d, prev_a, prev_b}) begin
                  miscompares++;
                  $display("FAIL resp_hold: got v=%b d=%h a=%h b=%h, expected v=1 d=%h a=%h b=%h",
                           resp_valid, resp_data, opa, opb, prev_d, prev_a, prev_b);
               end
            end
            if (resp_valid && !prev_rv) begin
               stable = 1'b1;
               for (int k = 1; k < LAT + 2; k++)
                  if (ha[k] !== opa || hb[k] !== opb || hf[k] !== fast) stable = 1'b0;
               vectors++;
               if (!stable) begin
                  miscompares++;
                  $display("FAIL wait_stable: got operands moving during wait, expected held a=%h b=%h", opa, opb);
               end
               vectors++;
               if (sb.size() == 0) begin
                  miscompares++;
                  $display("FAIL unexpected_resp: got resp_data=%h, expected no response", resp_data);
               end else begin
                  e   = sb[0];
                  sum = e.a + e.b;
                  if ({opa, opb, fast, resp_data, resp_zero} !== {e.a, e.b, e.f, sum, (sum == '0)}) begin
                     miscompares++;
                     $display("FAIL resp_data: got a=%h b=%h f=%b d=%h z=%b, expected a=%h b=%h f=%b d=%h z=%b",
                              opa, opb, fast, resp_data, resp_zero, e.a, e.b, e.f, sum, (sum == '0));
                  end
               end
            end
            if (resp_valid && resp_ready) begin
               vectors++;
               if (done_cnt !== exp_done) begin
                  miscompares++;
                  $display("FAIL done_cnt: got %0d, expected %0d", done_cnt, exp_done);
               end
               exp_done = exp_done + 1'b1;
               if (sb.size() > 0) void'(sb.pop_front());
            end
            prev_rv = resp_valid;
            prev_hs = resp_valid && resp_ready;
            prev_d  = resp_data;
            prev_a  = opa;
            prev_b  = opb;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_a      = '0;
      req_b      = '0;
      req_fast   = 1'b0;
      resp_ready = 1'b0;
      repeat (2) step();
      rst = 1'b0;
   endtask

   task automatic push_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic f);
      int w;
      w         = 0;
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_fast  = f;
      @(negedge clk);
      while (!req_ready && w < 40) begin
         w++;
         @(negedge clk);
      end
      if (!req_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL push_timeout: got req_ready=0, expected 1 within 40 cycles");
      end else begin
         sb.push_back('{a: a, b: b, f: f});
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_rv(input int budget, output int t);
      int n;
      n = 0;
      while (!resp_valid && n < budget) begin
         step();
         n++;
      end
      t = cyc;
      if (!resp_valid) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_resp: got resp_valid=0, expected 1 within %0d cycles", budget);
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((busy || resp_valid) && n < budget) begin
         step();
         n++;
      end
      if (busy || resp_valid) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: got busy=%b resp_valid=%b, expected idle", busy, resp_valid);
      end
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({opa, opb, fast} !== {{(2*WIDTH){1'b0}}, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_operands: got a=%h b=%h f=%b, expected 0", opa, opb, fast);
      end
      vectors++;
      if ({resp_data, done_cnt, resp_valid, resp_zero} !== {{WIDTH{1'b0}}, {CNT_W{1'b0}}, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_resp: got d=%h cnt=%0d v=%b z=%b, expected d=0 cnt=0 v=0 z=1",
                  resp_data, done_cnt, resp_valid, resp_zero);
      end
      vectors++;
      if ({busy, req_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL reset_status: got busy=%b req_ready=%b, expected busy=0 req_ready=1", busy, req_ready);
      end
   endtask

   task automatic test_single();
      int n;
      do_reset();
      resp_ready = 1'b1;
      push_req(32'd5, 32'd7, 1'b1);
      n = 0;
      while (!resp_valid && n < 20) begin
         step();
         n++;
      end
      vectors++;
      if (n != LAT + 2) begin
         miscompares++;
         $display("FAIL single_latency: got %0d cycles, expected %0d", n, LAT + 2);
      end
      vectors++;
      if ({resp_data, resp_zero} !== {32'd12, 1'b0}) begin
         miscompares++;
         $display("FAIL single_data: got d=%0d z=%b, expected d=12 z=0", resp_data, resp_zero);
      end
      step();
      vectors++;
      if (done_cnt !== CNT_W'(1)) begin
         miscompares++;
         $display("FAIL single_count: got %0d, expected 1", done_cnt);
      end
   endtask

   task automatic test_fill();
      int t [3];
      do_reset();
      for (int i = 0; i < 3; i++) push_req(WIDTH'(i * 16 + 1), WIDTH'(i + 100), i[0]);
      vectors++;
      if (req_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL fill_full: got req_ready=%b, expected 0", req_ready);
      end
      req_valid = 1'b1;
      req_a     = 32'hDEAD;
      req_b     = 32'hBEEF;
      repeat (4) begin
         step();
         vectors++;
         if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_hold: got req_ready=%b, expected 0", req_ready);
         end
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_rv(20, t[k]);
         step();
      end
      for (int k = 1; k < 3; k++) begin
         vectors++;
         if (t[k] - t[k-1] != LAT + 2) begin
            miscompares++;
            $display("FAIL fill_period: got %0d cycles, expected %0d", t[k] - t[k-1], LAT + 2);
         end
      end
      drain(20);
   endtask

   task automatic test_backpressure();
      int               t;
      logic [WIDTH-1:0] saved_d, saved_a;
      do_reset();
      push_req(32'h1234, 32'h10, 1'b0);
      wait_rv(20, t);
      saved_d = resp_data;
      saved_a = opa;
      push_req(32'hAAAA, 32'h5555, 1'b1);
      repeat (10) begin
         step();
         vectors++;
         if ({resp_valid, resp_data, opa} !== {1'b1, saved_d, saved_a}) begin
            miscompares++;
            $display("FAIL bp_hold: got v=%b d=%h a=%h, expected v=1 d=%h a=%h",
                     resp_valid, resp_data, opa, saved_d, saved_a);
         end
      end
      resp_ready = 1'b1;
      step();
      vectors++;
      if ({resp_valid, opa} !== {1'b0, 32'hAAAA}) begin
         miscompares++;
         $display("FAIL bp_issue: got v=%b a=%h, expected v=0 a=0000aaaa", resp_valid, opa);
      end
      drain(20);
   endtask

   task automatic test_zero_wrap();
      int t;
      do_reset();
      resp_ready = 1'b1;
      push_req(32'hFFFF_FFFF, 32'd1, 1'b0);
      wait_rv(20, t);
      vectors++;
      if ({resp_data, resp_zero} !== {32'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL zero: got d=%h z=%b, expected d=0 z=1", resp_data, resp_zero);
      end
      for (int i = 0; i < (1 << CNT_W) - 2; i++) push_req($urandom, $urandom, 1'($urandom_range(0, 1)));
      drain(40);
      vectors++;
      if (done_cnt !== {CNT_W{1'b1}}) begin
         miscompares++;
         $display("FAIL wrap_pre: got %0d, expected %0d", done_cnt, (1 << CNT_W) - 1);
      end
      push_req(32'd9, 32'd9, 1'b0);
      drain(20);
      vectors++;
      if (done_cnt !== '0) begin
         miscompares++;
         $display("FAIL wrap: got %0d, expected 0", done_cnt);
      end
   endtask

   task automatic test_reset_mid();
      logic seen;
      do_reset();
      resp_ready = 1'b1;
      push_req(32'd3, 32'd4, 1'b0);
      push_req(32'd8, 32'd9, 1'b1);
      step();
      rst = 1'b1;
      step();
      rst  = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         step();
         if (resp_valid) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_resp: got resp_valid=1, expected no response");
      end
      vectors++;
      if ({busy, req_ready, opa, opb, fast} !== {1'b0, 1'b1, {(2*WIDTH){1'b0}}, 1'b0}) begin
         miscompares++;
         $display("FAIL midrst_state: got busy=%b rdy=%b a=%h b=%h f=%b, expected 0 1 0 0 0",
                  busy, req_ready, opa, opb, fast);
      end
      vectors++;
      if ({resp_data, done_cnt} !== {{WIDTH{1'b0}}, {CNT_W{1'b0}}}) begin
         miscompares++;
         $display("FAIL midrst_resp_regs: got d=%h cnt=%0d, expected 0 0", resp_data, done_cnt);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         req_valid  = 1'($urandom_range(0, 1));
         req_a      = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
         req_b      = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
         req_fast   = 1'($urandom_range(0, 1));
         resp_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (req_valid && req_ready) sb.push_back('{a: req_a, b: req_b, f: req_fast});
         @(posedge clk);
         #1;
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      drain(200);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL random_leftover: got %0d pending, expected 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_backpressure();
      test_zero_wrap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
